// File: rtl/mipi_csi_tx_packet_encoder_8b2lane.sv
// CSI-2 transmit packet encoder for a 2-lane, 8-bit-per-lane byte stream.
// Emits sync, ECC-protected header, pulled payload and CRC-16 footer.
module mipi_csi_tx_packet_encoder_8b2lane #(
    parameter logic [7:0] SYNC_BYTE = 8'hB8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [1:0]  vc_i,
    input  logic [5:0]  dt_i,
    input  logic [15:0] wc_i,
    input  logic [15:0] data_i,
    output logic        data_req_o,
    output logic        ready_o,
    output logic        output_valid_o,
    output logic [15:0] data_o,
    output logic        error_o
);

    typedef enum logic [2:0] {IDLE, SYNC, HDR0, HDR1, PAYLOAD, CRC} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  di_reg, di_next;
    logic [15:0] wc_reg, wc_next;
    logic [15:0] crc_reg, crc_next;
    logic [14:0] cnt_reg, cnt_next;
    logic        ready_reg, ready_next;
    logic        valid_reg, valid_next;
    logic [15:0] data_reg, data_next;
    logic        req_reg, req_next;
    logic        error_reg, error_next;

    logic        long_pkt;
    logic        accept_long;
    logic [5:0]  ecc;

    // Reflected CCITT update: one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i])
                r = (r >> 1) ^ 16'h8408;
            else
                r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    // Data types 0x00-0x0F are short packets.
    assign long_pkt    = |di_reg[5:4];
    assign accept_long = |dt_i[5:4];
    assign ecc         = hdr_ecc({wc_reg, di_reg});

    always_comb begin
        state_next = state_reg;
        di_next    = di_reg;
        wc_next    = wc_reg;
        crc_next   = crc_reg;
        cnt_next   = cnt_reg;
        ready_next = 1'b0;
        valid_next = 1'b0;
        data_next  = 16'h0000;
        req_next   = 1'b0;
        error_next = 1'b0;

        case (state_reg)
            IDLE: begin
                ready_next = 1'b1;
                if (start_i) begin
                    state_next = SYNC;
                    ready_next = 1'b0;
                    valid_next = 1'b1;
                    data_next  = {SYNC_BYTE, SYNC_BYTE};
                    di_next    = {vc_i, dt_i};
                    wc_next    = accept_long ? {wc_i[15:1], 1'b0} : wc_i;
                    error_next = accept_long & wc_i[0];
                    crc_next   = 16'hFFFF;
                    cnt_next   = 15'd0;
                end
            end
            SYNC: begin
                state_next = HDR0;
                valid_next = 1'b1;
                data_next  = {wc_reg[7:0], di_reg};
            end
            HDR0: begin
                state_next = HDR1;
                valid_next = 1'b1;
                data_next  = {2'b00, ecc, wc_reg[15:8]};
                // Counter holds the number of beats still to come after the current one.
                cnt_next   = wc_reg[15:1] - 15'd1;
                req_next   = long_pkt && (wc_reg[15:1] != 15'd0);
            end
            HDR1: begin
                if (!long_pkt) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                end else if (wc_reg[15:1] == 15'd0) begin
                    state_next = CRC;
                    valid_next = 1'b1;
                    data_next  = crc_reg;
                end else begin
                    state_next = PAYLOAD;
                    valid_next = 1'b1;
                    data_next  = data_i;
                    crc_next   = crc16_byte(crc16_byte(crc_reg, data_i[7:0]), data_i[15:8]);
                    req_next   = (cnt_reg != 15'd0);
                end
            end
            PAYLOAD: begin
                valid_next = 1'b1;
                if (cnt_reg == 15'd0) begin
                    state_next = CRC;
                    data_next  = crc_reg;
                end else begin
                    data_next  = data_i;
                    crc_next   = crc16_byte(crc16_byte(crc_reg, data_i[7:0]), data_i[15:8]);
                    cnt_next   = cnt_reg - 15'd1;
                    req_next   = (cnt_reg != 15'd1);
                end
            end
            CRC: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
            di_reg    <= 8'h00;
            wc_reg    <= 16'h0000;
            crc_reg   <= 16'hFFFF;
            cnt_reg   <= 15'd0;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
            data_reg  <= 16'h0000;
            req_reg   <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            di_reg    <= di_next;
            wc_reg    <= wc_next;
            crc_reg   <= crc_next;
            cnt_reg   <= cnt_next;
            ready_reg <= ready_next;
            valid_reg <= valid_next;
            data_reg  <= data_next;
            req_reg   <= req_next;
            error_reg <= error_next;
        end
    end

    assign ready_o        = ready_reg;
    assign output_valid_o = valid_reg;
    assign data_o         = data_reg;
    assign data_req_o     = req_reg;
    assign error_o        = error_reg;

endmodule

// File: tb/tb_mipi_csi_tx_packet_encoder_8b2lane.sv
// Self-checking bench for the CSI-2 TX packet encoder: directed vectors,
// boundary word counts, start contention, mid-packet reset and random packets.
`timescale 1ns/1ps
module tb_mipi_csi_tx_packet_encoder_8b2lane;

    localparam logic [7:0] SYNC = 8'hB8;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  vc_i = 2'd0;
    logic [5:0]  dt_i = 6'd0;
    logic [15:0] wc_i = 16'd0;
    logic [15:0] data_i = 16'd0;
    logic        data_req_o, ready_o, output_valid_o, error_o;
    logic [15:0] data_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] payload_mem [0:63];
    logic [15:0] crc_tbl [0:255];

    // ECC code contributed by each header bit (column view of the Hamming matrix).
    localparam logic [5:0] ECC_COL [0:23] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    localparam logic [7:0] V1 [0:23] = '{
        8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
        8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    localparam logic [7:0] V2 [0:23] = '{
        8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7, 8'h4F, 8'h82, 8'h78, 8'hC5,
        8'h82, 8'hE0, 8'h8C, 8'h70, 8'hD2, 8'h3C, 8'h78, 8'hE9, 8'hFF, 8'h00, 8'h00, 8'h01};

    mipi_csi_tx_packet_encoder_8b2lane #(.SYNC_BYTE(SYNC)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .vc_i           (vc_i),
        .dt_i           (dt_i),
        .wc_i           (wc_i),
        .data_i         (data_i),
        .data_req_o     (data_req_o),
        .ready_o        (ready_o),
        .output_valid_o (output_valid_o),
        .data_o         (data_o),
        .error_o        (error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] ref_ecc(input logic [23:0] d);
        logic [5:0] e;
        e = 6'd0;
        for (int i = 0; i < 24; i++)
            if (d[i]) e = e ^ ECC_COL[i];
        return e;
    endfunction

    // Table-driven byte-at-a-time CRC over the first nwords payload words.
    function automatic logic [15:0] ref_crc(input int nwords);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int i = 0; i < nwords; i++) begin
            for (int l = 0; l < 2; l++) begin
                b = (l == 0) ? payload_mem[i][7:0] : payload_mem[i][15:8];
                c = (c >> 8) ^ crc_tbl[c[7:0] ^ b];
            end
        end
        return c;
    endfunction

    task automatic reset_check(input string tag);
        chk({tag, "_valid"}, 32'(output_valid_o), 32'd0);
        chk({tag, "_data"},  32'(data_o), 32'd0);
        chk({tag, "_req"},   32'(data_req_o), 32'd0);
        chk({tag, "_ready"}, 32'(ready_o), 32'd1);
        chk({tag, "_err"},   32'(error_o), 32'd0);
    endtask

    // Issues one request and checks every output cycle until the idle beat that follows.
    task automatic send(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                        input bit hold, input int abort_at, output logic [15:0] crc_seen);
        bit          lng;
        logic [15:0] wce;
        int          n, beats, widx;
        logic [15:0] exp_d;
        bit          exp_req;
        lng   = (dt >= 6'h10);
        wce   = lng ? {wc[15:1], 1'b0} : wc;
        n     = lng ? int'(wce[15:1]) : 0;
        beats = lng ? 4 + n : 3;
        widx  = 0;
        crc_seen = 16'h0000;
        vc_i = vc; dt_i = dt; wc_i = wc; start_i = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_i = 1'b0;
        for (int c = 0; c <= beats; c++) begin
            if (c == 0)                  exp_d = {SYNC, SYNC};
            else if (c == 1)             exp_d = {wce[7:0], vc, dt};
            else if (c == 2)             exp_d = {2'b00, ref_ecc({wce, vc, dt}), wce[15:8]};
            else if (c < beats && c < 3 + n) exp_d = payload_mem[c - 3];
            else if (c < beats)          exp_d = ref_crc(n);
            else                         exp_d = 16'h0000;
            exp_req = lng && c >= 2 && c <= 1 + n;
            $display("pkt vc=%0d dt=%h wc=%0d cyc=%0d data_o=%h exp=%h valid=%0d req=%0d",
                     vc, dt, wc, c, data_o, exp_d, output_valid_o, data_req_o);
            chk("data", 32'(data_o), 32'(exp_d));
            chk("valid", 32'(output_valid_o), 32'(c < beats));
            chk("ready", 32'(ready_o), 32'(c >= beats));
            chk("data_req", 32'(data_req_o), 32'(exp_req));
            chk("error", 32'(error_o), 32'(c == 0 && lng && wc[0]));
            if (lng && c == 3 + n) crc_seen = data_o;
            if (c == abort_at) begin
                #1 reset_i = 1'b1;
                #1 reset_check("midreset");
                @(posedge clk); @(posedge clk); #1;
                reset_i = 1'b0;
                start_i = 1'b0;
                return;
            end
            if (c < beats) begin
                vc_i = 2'($urandom); dt_i = 6'($urandom); wc_i = 16'($urandom);
                data_i = exp_req ? payload_mem[widx] : 16'($urandom);
                if (exp_req) widx++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) payload_mem[i] = 16'($urandom);
    endtask

    logic [15:0] crc_seen;
    logic [5:0]  rdt;
    logic [15:0] rwc;

    initial begin
        for (int v = 0; v < 256; v++) begin
            logic [15:0] r;
            r = 16'(v);
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
            crc_tbl[v] = r;
        end

        // Reset state, both while held and after release.
        repeat (3) @(posedge clk);
        #1 reset_check("in_reset");
        reset_i = 1'b0;
        @(posedge clk); #1 reset_check("after_reset");

        // Short frame-start packet.
        fill_random();
        send(2'd0, 6'h00, 16'h0001, 1'b0, -1, crc_seen);

        // Known CRC vectors.
        for (int i = 0; i < 12; i++) payload_mem[i] = {V1[2*i+1], V1[2*i]};
        send(2'd0, 6'h2B, 16'd24, 1'b0, -1, crc_seen);
        chk("crc_vec1", 32'(crc_seen), 32'h00F0);
        for (int i = 0; i < 12; i++) payload_mem[i] = {V2[2*i+1], V2[2*i]};
        send(2'd0, 6'h2B, 16'd24, 1'b0, -1, crc_seen);
        chk("crc_vec2", 32'(crc_seen), 32'hE569);

        // Boundary word counts.
        fill_random();
        send(2'd1, 6'h2A, 16'd0, 1'b0, -1, crc_seen);
        chk("crc_wc0", 32'(crc_seen), 32'hFFFF);
        send(2'd2, 6'h2B, 16'd25, 1'b0, -1, crc_seen);
        send(2'd3, 6'h12, 16'd2, 1'b0, -1, crc_seen);

        // start_i held high across back-to-back packets.
        fill_random();
        send(2'd1, 6'h2C, 16'd6, 1'b1, -1, crc_seen);
        send(2'd2, 6'h01, 16'hBEEF, 1'b1, -1, crc_seen);
        send(2'd0, 6'h2B, 16'd4, 1'b1, -1, crc_seen);
        start_i = 1'b0;
        @(posedge clk); #1 reset_check("contention_idle");

        // Reset during payload beat 5, then a clean packet.
        fill_random();
        send(2'd0, 6'h2B, 16'd64, 1'b0, 7, crc_seen);
        reset_check("post_abort");
        fill_random();
        send(2'd1, 6'h2B, 16'd64, 1'b0, -1, crc_seen);

        // Random packets with random idle gaps.
        for (int p = 0; p < 20; p++) begin
            fill_random();
            if ($urandom_range(0, 1) == 0) begin
                rdt = 6'($urandom_range(0, 15));
                rwc = 16'($urandom);
            end else begin
                rdt = 6'($urandom_range(16, 63));
                rwc = 16'($urandom_range(0, 41));
            end
            send(2'($urandom), rdt, rwc, 1'b0, -1, crc_seen);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
